// File: rtl/matrix_pkg.sv
// Shared types and geometry for the matrix operand server and its word RAMs.
package matrix_pkg;

    localparam int N          = 32;
    localparam int DW         = 8;
    localparam int WORD_BYTES = 32;
    localparam int WORD_W     = WORD_BYTES * DW;
    localparam int LANE_W     = $clog2(WORD_BYTES);
    localparam int AW         = 5;
    localparam int IW         = 6;

    typedef logic [N-1:0][DW-1:0] vec_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ISSUE0 = 3'd2,
        ISSUE1 = 3'd3,
        WAIT   = 3'd4,
        RESP   = 3'd5,
        HOLD   = 3'd6
    } srv_state_t;

endpackage

// File: rtl/matrix_word_ram.sv
// Single-port read-first word RAM with a fixed multi-cycle read pipeline.
module matrix_word_ram #(
    parameter int AW          = 5,
    parameter int WIDTH       = 256,
    parameter int RAM_LATENCY = 2
) (
    input  logic             clk_in,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r  [1<<AW];
    logic [WIDTH-1:0] pipe_r [RAM_LATENCY];

    // Storage write port; contents are not reset and need a reload after reset.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read-first pipeline: the first stage samples the old word before any write lands.
    always_ff @(posedge clk_in) begin
        pipe_r[0] <= mem_r[addr];
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign rdata = pipe_r[RAM_LATENCY-1];

endmodule

// File: rtl/matrix_operand_server.sv
// Loads A (row-major) and B (column-major) from a byte stream, then serves row/column pairs.
module matrix_operand_server
    import matrix_pkg::*;
#(
    parameter int N           = 32,
    parameter int RAM_LATENCY = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    input  logic          new_request,
    input  logic [5:0]    row1_req,
    input  logic [5:0]    row2_req,
    input  logic [5:0]    col1_req,
    input  logic [5:0]    col2_req,
    output logic          complete,
    output vec_t          matA_row1,
    output vec_t          matA_row2,
    output vec_t          matB_col1,
    output vec_t          matB_col2,
    output logic [5:0]    row1_in,
    output logic [5:0]    row2_in,
    output logic [5:0]    col1_in,
    output logic [5:0]    col2_in,
    output logic          val_rows
);

    localparam int            CW        = $clog2(2 * N * N);
    localparam logic [CW-1:0] LAST_BYTE = CW'(2 * N * N - 1);
    localparam logic [CW-1:0] A_BYTES   = CW'(N * N);

    srv_state_t        state_r, next_state_s;
    logic [CW-1:0]     count_r;
    logic [WORD_W-1:0] pack_r;
    logic [IW-1:0]     row1_q_r, row2_q_r, col1_q_r, col2_q_r;
    vec_t              a1_hold_r, b1_hold_r;
    logic              tag_v_r [RAM_LATENCY];
    logic              tag_s_r [RAM_LATENCY];

    logic              start_ok_s, byte_acc_s, word_done_s, last_byte_s, accept_s;
    logic              issue_s, issue_slot_s, first_ret_s, second_ret_s, resp_load_s;
    logic              we_a_s, we_b_s;
    logic [AW-1:0]     addr_a_s, addr_b_s;
    logic [WORD_W-1:0] wdata_s, rdata_a_s, rdata_b_s;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; load_start only has effect in IDLE/LOAD.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    next_state_s = LOAD;
                end else if (new_request && complete) begin
                    next_state_s = ISSUE0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (load_start) begin
                    next_state_s = LOAD;
                end else if (last_byte_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = LOAD;
                end
            end
            ISSUE0:  next_state_s = ISSUE1;
            ISSUE1:  next_state_s = WAIT;
            WAIT:    next_state_s = second_ret_s ? RESP : WAIT;
            RESP:    next_state_s = HOLD;
            HOLD:    next_state_s = new_request ? HOLD : IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output/decode logic: loader strobes, RAM ports and read-return tracking.
    always_comb begin
        start_ok_s   = load_start && ((state_r == IDLE) || (state_r == LOAD));
        byte_acc_s   = (state_r == LOAD) && load_valid && !load_start;
        word_done_s  = byte_acc_s && (count_r[LANE_W-1:0] == 5'd31);
        last_byte_s  = byte_acc_s && (count_r == LAST_BYTE);
        accept_s     = (state_r == IDLE) && !load_start && new_request && complete;
        first_ret_s  = tag_v_r[RAM_LATENCY-1] && !tag_s_r[RAM_LATENCY-1];
        second_ret_s = tag_v_r[RAM_LATENCY-1] && tag_s_r[RAM_LATENCY-1];
        resp_load_s  = (state_r == WAIT) && second_ret_s;
        wdata_s      = {load_data, pack_r[WORD_W-DW-1:0]};
        we_a_s       = 1'b0;
        we_b_s       = 1'b0;
        addr_a_s     = '0;
        addr_b_s     = '0;
        issue_s      = 1'b0;
        issue_slot_s = 1'b0;
        case (state_r)
            LOAD: begin
                addr_a_s = count_r[AW+LANE_W-1:LANE_W];
                addr_b_s = count_r[AW+LANE_W-1:LANE_W];
                we_a_s   = word_done_s && (count_r < A_BYTES);
                we_b_s   = word_done_s && (count_r >= A_BYTES);
            end
            ISSUE0: begin
                addr_a_s = row1_q_r[AW-1:0];
                addr_b_s = col1_q_r[AW-1:0];
                issue_s  = 1'b1;
            end
            ISSUE1: begin
                addr_a_s     = row2_q_r[AW-1:0];
                addr_b_s     = col2_q_r[AW-1:0];
                issue_s      = 1'b1;
                issue_slot_s = 1'b1;
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    // Datapath: byte packer, load counter, request capture and response registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_r   <= '0;
            pack_r    <= '0;
            complete  <= 1'b0;
            row1_q_r  <= '0;
            row2_q_r  <= '0;
            col1_q_r  <= '0;
            col2_q_r  <= '0;
            a1_hold_r <= '0;
            b1_hold_r <= '0;
            matA_row1 <= '0;
            matA_row2 <= '0;
            matB_col1 <= '0;
            matB_col2 <= '0;
            row1_in   <= '0;
            row2_in   <= '0;
            col1_in   <= '0;
            col2_in   <= '0;
            val_rows  <= 1'b0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_v_r[i] <= 1'b0;
                tag_s_r[i] <= 1'b0;
            end
        end else begin
            if (start_ok_s) begin
                count_r  <= '0;
                complete <= 1'b0;
            end else if (byte_acc_s) begin
                count_r <= count_r + CW'(1);
                pack_r[{count_r[LANE_W-1:0], 3'b000} +: DW] <= load_data;
                if (last_byte_s) begin
                    complete <= 1'b1;
                end
            end
            if (accept_s) begin
                row1_q_r <= row1_req;
                row2_q_r <= row2_req;
                col1_q_r <= col1_req;
                col2_q_r <= col2_req;
            end
            // Tags follow each read through the RAM pipeline so returns are matched to slots.
            tag_v_r[0] <= issue_s;
            tag_s_r[0] <= issue_slot_s;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_v_r[i] <= tag_v_r[i-1];
                tag_s_r[i] <= tag_s_r[i-1];
            end
            if (first_ret_s) begin
                a1_hold_r <= rdata_a_s;
                b1_hold_r <= rdata_b_s;
            end
            if (resp_load_s) begin
                matA_row1 <= a1_hold_r;
                matB_col1 <= b1_hold_r;
                matA_row2 <= rdata_a_s;
                matB_col2 <= rdata_b_s;
                row1_in   <= row1_q_r;
                row2_in   <= row2_q_r;
                col1_in   <= col1_q_r;
                col2_in   <= col2_q_r;
            end
            val_rows <= (next_state_s == RESP);
        end
    end

    matrix_word_ram #(.AW(AW), .WIDTH(WORD_W), .RAM_LATENCY(RAM_LATENCY)) u_ram_a (
        .clk_in (clk_in),
        .we     (we_a_s),
        .addr   (addr_a_s),
        .wdata  (wdata_s),
        .rdata  (rdata_a_s)
    );

    matrix_word_ram #(.AW(AW), .WIDTH(WORD_W), .RAM_LATENCY(RAM_LATENCY)) u_ram_b (
        .clk_in (clk_in),
        .we     (we_b_s),
        .addr   (addr_b_s),
        .wdata  (wdata_s),
        .rdata  (rdata_b_s)
    );

endmodule

// File: tb/tb_matrix_operand_server.sv
// Randomized bench for matrix_operand_server against an array-based matrix model.
module tb_matrix_operand_server;
    import matrix_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_in, load_start, load_valid, new_request;
    logic [7:0] load_data;
    logic [5:0] row1_req, row2_req, col1_req, col2_req;
    logic       complete, val_rows;
    vec_t       matA_row1, matA_row2, matB_col1, matB_col2;
    logic [5:0] row1_in, row2_in, col1_in, col2_in;

    logic [7:0] ma [32][32];
    logic [7:0] mb [32][32];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         strobes = 0;
    int         last_cyc, at, t0, s0;

    matrix_operand_server #(.N(32), .RAM_LATENCY(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .new_request(new_request), .row1_req(row1_req),
        .row2_req(row2_req), .col1_req(col1_req), .col2_req(col2_req), .complete(complete),
        .matA_row1(matA_row1), .matA_row2(matA_row2), .matB_col1(matB_col1),
        .matB_col2(matB_col2), .row1_in(row1_in), .row2_in(row2_in), .col1_in(col1_in),
        .col2_in(col2_in), .val_rows(val_rows)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
        if (val_rows === 1'b1) strobes++;
    endtask

    function automatic logic [255:0] a_row(input logic [5:0] r);
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[k*8 +: 8] = ma[r[4:0]][k];
        return v;
    endfunction

    function automatic logic [255:0] b_col(input logic [5:0] c);
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[k*8 +: 8] = mb[k][c[4:0]];
        return v;
    endfunction

    // Streams A row-major then B column-major, optionally with idle gaps.
    task automatic load_all(input bit gaps);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = 8'($urandom); tick();
        end
        load_valid = 1'b0; load_start = 1'b1; tick();
        load_start = 1'b0;
        for (int b = 0; b < 2048; b++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    load_valid = 1'b0; load_data = 8'($urandom); tick();
                end
            end
            load_valid = 1'b1;
            load_data  = (b < 1024) ? ma[b / 32][b % 32] : mb[(b - 1024) % 32][(b - 1024) / 32];
            if (b == 2047) check_eq("complete_before_last", complete, 1'b0);
            tick();
        end
        load_valid = 1'b0;
        last_cyc   = cyc - 1;
        check_eq("complete_after_last", complete, 1'b1);
    endtask

    task automatic wait_strobe(input bit scramble, input bit poke, output int when);
        when = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            load_start = (poke && i == 0);
            if (scramble) begin
                row1_req = 6'($urandom); row2_req = 6'($urandom);
                col1_req = 6'($urandom); col2_req = 6'($urandom);
            end
            if (val_rows === 1'b1) begin
                when = cyc;
                break;
            end
        end
        load_start = 1'b0;
    endtask

    task automatic check_resp(input logic [5:0] r1, r2, c1, c2);
        check_eq("matA_row1", matA_row1, a_row(r1));
        check_eq("matA_row2", matA_row2, a_row(r2));
        check_eq("matB_col1", matB_col1, b_col(c1));
        check_eq("matB_col2", matB_col2, b_col(c2));
        check_eq("row1_in", row1_in, r1);
        check_eq("row2_in", row2_in, r2);
        check_eq("col1_in", col1_in, c1);
        check_eq("col2_in", col2_in, c2);
    endtask

    // Keeps the request high past the strobe, then drops it for one cycle.
    task automatic hold_and_release(input logic [5:0] r1);
        int s;
        s = strobes;
        repeat (10) tick();
        check_eq("no_second_strobe", strobes, s);
        check_eq("held_matA_row1", matA_row1, a_row(r1));
        new_request = 1'b0;
        tick();
    endtask

    task automatic do_req(input logic [5:0] r1, r2, c1, c2, input bit poke);
        int t;
        row1_req = r1; row2_req = r2; col1_req = c1; col2_req = c2;
        new_request = 1'b1;
        t = cyc;
        wait_strobe(1'b1, poke, at);
        check_eq("strobe_latency", at - t, 5);
        check_resp(r1, r2, c1, c2);
        check_eq("complete_kept", complete, 1'b1);
        hold_and_release(r1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_outs"}, {matA_row1 | matA_row2 | matB_col1 | matB_col2}, 256'd0);
        check_eq({tag, "_idx"}, {row1_in, row2_in, col1_in, col2_in}, 24'd0);
        check_eq({tag, "_val"}, val_rows, 1'b0);
        check_eq({tag, "_complete"}, complete, 1'b0);
    endtask

    initial begin
        logic [5:0] r1, r2, c1, c2;
        rst_in = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 8'd0;
        new_request = 1'b0; row1_req = 6'd0; row2_req = 6'd0; col1_req = 6'd0; col2_req = 6'd0;
        repeat (3) tick();
        rst_in = 1'b0;
        check_zero_outputs("reset");
        new_request = 1'b1;
        repeat (8) tick();
        check_eq("no_strobe_unloaded", strobes, 0);
        new_request = 1'b0;
        tick();

        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) begin
                ma[i][j] = 8'(i + j);
                mb[i][j] = 8'(i - j);
            end
        load_all(1'b0);
        do_req(6'd3, 6'd17, 6'd0, 6'd31, 1'b0);
        for (int n = 0; n < 6; n++) begin
            do_req(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), (n == 2));
        end

        // Reset while the server is in WAIT.
        row1_req = 6'd5; row2_req = 6'd6; col1_req = 6'd7; col2_req = 6'd8;
        new_request = 1'b1;
        repeat (3) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_zero_outputs("wait_reset");
        s0 = strobes;
        repeat (8) tick();
        check_eq("no_strobe_after_reset", strobes, s0);

        // Reload with random data while a request is already pending.
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) begin
                ma[i][j] = 8'($urandom);
                mb[i][j] = 8'($urandom);
            end
        r1 = 6'($urandom); r2 = 6'($urandom); c1 = 6'($urandom); c2 = 6'($urandom);
        row1_req = r1; row2_req = r2; col1_req = c1; col2_req = c2;
        load_all(1'b1);
        wait_strobe(1'b0, 1'b0, at);
        check_eq("pending_latency", at - last_cyc, 6);
        check_resp(r1, r2, c1, c2);
        hold_and_release(r1);
        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            do_req(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), 1'b0);
        end
        t0 = cyc;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
